// File: rtl/l3_neuron_pkg.sv
// Shared encodings for the time-multiplexed neuron: activation modes, FSM states and the
// leaky-ReLU slope shift.
package l3_neuron_pkg;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RELU  = 2'b01;
  localparam logic [1:0] ACT_LEAKY = 2'b10;

  localparam int unsigned LEAKY_SHIFT = 3;

  typedef enum logic [1:0] {
    StAcc,
    StPost,
    StOut
  } state_e;

endpackage

// File: rtl/neuron_act_sat.sv
// Post-processing for one neuron: drop fractional bits, apply the activation and clamp the
// result into the signed WIDTH-bit range.
module neuron_act_sat
  import l3_neuron_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned FRAC  = 0
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] t;
  logic signed [ACC_W-1:0] a;

  always_comb begin
    t = $signed(acc) >>> FRAC;
    a = t;
    case (mode)
      ACT_RELU:  if (t[ACC_W-1]) a = '0;
      ACT_LEAKY: if (t[ACC_W-1]) a = t >>> LEAKY_SHIFT;
      default:   a = t;
    endcase

    y   = a[WIDTH-1:0];
    sat = 1'b0;
    if (a > MAXV) begin
      y   = MAXV[WIDTH-1:0];
      sat = 1'b1;
    end else if (a < MINV) begin
      y   = MINV[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/l3_neuron.sv
// Time-multiplexed neuron: accumulates N x*w products LANES per beat, adds the bias and emits
// one activated, saturated result per neuron under valid/ready handshakes.
module l3_neuron
  import l3_neuron_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             act_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] x,
  input  logic [LANES*WIDTH-1:0] w,
  input  logic [WIDTH-1:0]       b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       y,
  output logic                   sat
);

  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N) + 1;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (N % LANES != 0) begin : g_bad_n
    $error("l3_neuron: N must be a multiple of LANES");
  end
  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("l3_neuron: FRAC must be smaller than WIDTH");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]              mode_q, mode_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [2*WIDTH-1:0] prod [LANES];
  logic signed [ACC_W-1:0]   psum;
  logic signed [ACC_W-1:0]   bias_ext;
  logic [WIDTH-1:0]          y_post;
  logic                      sat_post;

  always_comb begin
    psum = '0;
    for (int k = 0; k < LANES; k++) begin
      prod[k] = $signed(x[k*WIDTH +: WIDTH]) * $signed(w[k*WIDTH +: WIDTH]);
      psum    = psum + {{(ACC_W-2*WIDTH){prod[k][2*WIDTH-1]}}, prod[k]};
    end
  end

  // Bias is aligned to the product scale (2*FRAC fractional bits) before accumulation.
  assign bias_ext = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b} <<< FRAC;

  neuron_act_sat #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W),
    .FRAC (FRAC)
  ) u_act_sat (
    .acc (acc_q),
    .mode(mode_q),
    .y   (y_post),
    .sat (sat_post)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    y_d         = y_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StAcc: begin
        if (in_valid) begin
          if (cnt_q == '0) begin
            acc_d  = bias_ext + psum;
            mode_d = act_mode;
          end else begin
            acc_d = acc_q + psum;
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = StPost;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPost: begin
        y_d         = y_post;
        sat_d       = sat_post;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      cnt_q       <= '0;
      acc_q       <= '0;
      mode_q      <= ACT_NONE;
      y_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;

endmodule
